fibonacci_stream_checker: RTL

Downstream consumer of the Fibonacci generators. Samples a single-rate or double-rate stream of terms, checks that every term from the third onward equals the modulo-2^W sum of the two previous terms, and counts accepted terms. On the first mismatch or protocol violation it latches diagnostic data and stops. It is used as an in-fabric self-check behind `fibonacci` and `fibonacci_2`.

---
 rtl/fibonacci_stream_checker.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/fibonacci_stream_checker.sv
`default_nettype none
// ============================================================================
// Module      : fibonacci_stream_checker
// Description : Checks a single- or double-rate stream of Fibonacci terms.
//               Every term after the two seeds must equal the modulo-2^W sum
//               of the two preceding terms. Accepted terms are counted; the
//               first mismatch or protocol violation latches diagnostics and
//               parks the checker in an absorbing FAIL state.
// Revision    : 1.0 - initial release
// ============================================================================
module fibonacci_stream_checker #(
    parameter int W     = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    input  logic             i_in_valid2,
    input  logic [W-1:0]     i_num,
    input  logic [W-1:0]     i_num2,
    output logic [CNT_W-1:0] o_count,
    output logic             o_err,
    output logic             o_proto_err,
    output logic [CNT_W-1:0] o_err_index,
    output logic [W-1:0]     o_err_expected,
    output logic [W-1:0]     o_err_actual
);

    // SEED0: no history, SEED1: one term held, RUN: two terms held
    typedef enum logic [1:0] {
        S_SEED0 = 2'd0,
        S_SEED1 = 2'd1,
        S_RUN   = 2'd2,
        S_FAIL  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    // ------------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------------
    state_t             r_state;
    logic [W-1:0]       r_prev1;
    logic [W-1:0]       r_prev2;
    logic [CNT_W-1:0]   r_count;
    logic               r_err;
    logic               r_proto_err;
    logic [CNT_W-1:0]   r_err_index;
    logic [W-1:0]       r_err_expected;
    logic [W-1:0]       r_err_actual;

    // ------------------------------------------------------------------------
    // Per-cycle evaluation results
    // ------------------------------------------------------------------------
    logic [W-1:0]       w_term [2];
    logic [1:0]         w_lane_valid;
    state_t             w_state;
    logic [W-1:0]       w_prev1;
    logic [W-1:0]       w_prev2;
    logic [W-1:0]       w_sum;
    logic [1:0]         w_acc;
    logic               w_mis;
    logic               w_mis_lane;
    logic [W-1:0]       w_mis_exp;
    logic [W-1:0]       w_mis_act;
    logic               w_proto;
    logic [CNT_W:0]     w_cnt_ext;
    logic [CNT_W-1:0]   w_count_next;
    logic [CNT_W-1:0]   w_err_index;

    // Lane 1 only exists when lane 0 is also present; a lone in_valid2 is a
    // protocol error handled separately below.
    assign w_term[0]       = i_num;
    assign w_term[1]       = i_num2;
    assign w_lane_valid[0] = i_in_valid;
    assign w_lane_valid[1] = i_in_valid & i_in_valid2;

    // Walk lane 0 then lane 1 through the seed/check sequence, so that a lane 1
    // check sees the history already updated by lane 0 in the same cycle.
    always_comb begin
        w_state    = r_state;
        w_prev1    = r_prev1;
        w_prev2    = r_prev2;
        w_sum      = '0;
        w_acc      = 2'd0;
        w_mis      = 1'b0;
        w_mis_lane = 1'b0;
        w_mis_exp  = '0;
        w_mis_act  = '0;
        w_proto    = 1'b0;

        if (r_state != S_FAIL) begin
            if (i_in_valid2 && !i_in_valid) begin
                w_proto = 1'b1;
                w_state = S_FAIL;
            end else begin
                for (int l = 0; l < 2; l++) begin
                    if (w_lane_valid[l] && !w_mis) begin
                        // Truncating add gives the modulo-2^W sum directly.
                        w_sum = w_prev2 + w_prev1;
                        case (w_state)
                            S_SEED0: begin
                                w_prev1 = w_term[l];
                                w_state = S_SEED1;
                                w_acc   = w_acc + 2'd1;
                            end
                            S_SEED1: begin
                                w_prev2 = w_prev1;
                                w_prev1 = w_term[l];
                                w_state = S_RUN;
                                w_acc   = w_acc + 2'd1;
                            end
                            S_RUN: begin
                                if (w_term[l] == w_sum) begin
                                    w_prev2 = w_prev1;
                                    w_prev1 = w_term[l];
                                    w_acc   = w_acc + 2'd1;
                                end else begin
                                    // A lane 0 failure masks lane 1 through w_mis.
                                    w_mis      = 1'b1;
                                    w_mis_lane = (l == 1);
                                    w_mis_exp  = w_sum;
                                    w_mis_act  = w_term[l];
                                    w_state    = S_FAIL;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            end
        end
    end

    // Saturating counter update; the extra MSB flags overflow past the maximum.
    always_comb begin
        w_cnt_ext = {1'b0, r_count} + {{(CNT_W-1){1'b0}}, w_acc};
        if (w_cnt_ext[CNT_W]) begin
            w_count_next = c_CNT_MAX;
        end else begin
            w_count_next = w_cnt_ext[CNT_W-1:0];
        end
    end

    // Index of the failing term: count before this cycle plus its lane offset.
    assign w_err_index = r_count + {{(CNT_W-1){1'b0}}, w_mis_lane};

    // State, history, counter and diagnostics; FAIL freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_SEED0;
            r_prev1        <= '0;
            r_prev2        <= '0;
            r_count        <= '0;
            r_err          <= 1'b0;
            r_proto_err    <= 1'b0;
            r_err_index    <= '0;
            r_err_expected <= '0;
            r_err_actual   <= '0;
        end else if (r_state != S_FAIL) begin
            r_state <= w_state;
            r_prev1 <= w_prev1;
            r_prev2 <= w_prev2;
            r_count <= w_count_next;
            if (w_mis) begin
                r_err          <= 1'b1;
                r_err_index    <= w_err_index;
                r_err_expected <= w_mis_exp;
                r_err_actual   <= w_mis_act;
            end
            if (w_proto) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign o_count        = r_count;
    assign o_err          = r_err;
    assign o_proto_err    = r_proto_err;
    assign o_err_index    = r_err_index;
    assign o_err_expected = r_err_expected;
    assign o_err_actual   = r_err_actual;

endmodule
`default_nettype wire
